// File: rtl/rank_pkg.sv
// ============================================================================
//  Module      : rank_pkg
//  Description : Shared constants for the 3x3 rank-order filter slice.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package rank_pkg;

    localparam logic [1:0] MODE_MEDIAN = 2'd0;
    localparam logic [1:0] MODE_MIN    = 2'd1;
    localparam logic [1:0] MODE_MAX    = 2'd2;
    localparam logic [1:0] MODE_BYPASS = 2'd3;

    localparam int BORDER_ZERO      = 0;
    localparam int BORDER_REPLICATE = 1;

    localparam int WIN_ROWS = 3;
    localparam int WIN_TAPS = WIN_ROWS * WIN_ROWS;

endpackage

`default_nettype wire

// File: rtl/rank9_sorter.sv
// ============================================================================
//  Module      : rank9_sorter
//  Description : Combinational 9-input rank network: min, median and max.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rank9_sorter
    import rank_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [WIN_TAPS*DATA_W-1:0] win_i,
    output logic [DATA_W-1:0]          min_o,
    output logic [DATA_W-1:0]          med_o,
    output logic [DATA_W-1:0]          max_o
);

    logic [DATA_W-1:0] tap [WIN_TAPS];
    logic [DATA_W-1:0] p   [WIN_TAPS];

    genvar gi;
    generate
        for (gi = 0; gi < WIN_TAPS; gi++) begin : g_unpack
            assign tap[gi] = win_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Compare-and-swap: returns {smaller, larger}.
    function automatic logic [2*DATA_W-1:0] cas(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return (a > b) ? {b, a} : {a, b};
    endfunction

    // 19-exchange median network; only p[4] is guaranteed ranked at the end.
    always_comb begin
        p = tap;
        {p[1], p[2]} = cas(p[1], p[2]);
        {p[4], p[5]} = cas(p[4], p[5]);
        {p[7], p[8]} = cas(p[7], p[8]);
        {p[0], p[1]} = cas(p[0], p[1]);
        {p[3], p[4]} = cas(p[3], p[4]);
        {p[6], p[7]} = cas(p[6], p[7]);
        {p[1], p[2]} = cas(p[1], p[2]);
        {p[4], p[5]} = cas(p[4], p[5]);
        {p[7], p[8]} = cas(p[7], p[8]);
        {p[0], p[3]} = cas(p[0], p[3]);
        {p[5], p[8]} = cas(p[5], p[8]);
        {p[4], p[7]} = cas(p[4], p[7]);
        {p[3], p[6]} = cas(p[3], p[6]);
        {p[1], p[4]} = cas(p[1], p[4]);
        {p[2], p[5]} = cas(p[2], p[5]);
        {p[4], p[7]} = cas(p[4], p[7]);
        {p[4], p[2]} = cas(p[4], p[2]);
        {p[6], p[4]} = cas(p[6], p[4]);
        {p[4], p[2]} = cas(p[4], p[2]);
    end

    assign med_o = p[4];

    always_comb begin
        min_o = win_i[DATA_W-1:0];
        max_o = win_i[DATA_W-1:0];
        for (int i = 1; i < WIN_TAPS; i++) begin
            if (win_i[i*DATA_W +: DATA_W] < min_o) begin
                min_o = win_i[i*DATA_W +: DATA_W];
            end
            if (win_i[i*DATA_W +: DATA_W] > max_o) begin
                max_o = win_i[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rank3x3_stream.sv
// ============================================================================
//  Module      : rank3x3_stream
//  Description : Streaming 3x3 rank-order filter (median/min/max/bypass).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rank3x3_stream
    import rank_pkg::*;
#(
    parameter int W           = 160,
    parameter int H           = 120,
    parameter int DATA_W      = 8,
    parameter int BORDER_MODE = BORDER_REPLICATE
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pixel,
    input  logic              in_sof,
    input  logic              in_eol,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pixel,
    output logic              out_sof,
    output logic              out_eol,
    output logic              len_err
);

    localparam int             XW     = $clog2(W);
    localparam int             YW     = $clog2(H);
    localparam logic [XW-1:0]  X_LAST = XW'(W - 1);
    localparam logic [YW-1:0]  Y_LAST = YW'(H - 1);

    logic                          accept;
    logic [XW-1:0]                 x_q, x_d, x_cur;
    logic [YW-1:0]                 y_q, y_d, y_cur;
    logic                          x_last;
    logic [1:0]                    mode_q, mode_d, mode_cur;
    logic                          len_err_q, len_err_d;

    logic [DATA_W-1:0]             lb0_q [W];
    logic [DATA_W-1:0]             lb1_q [W];
    logic [DATA_W-1:0]             lb0_rd, lb1_rd;

    // Column vectors: index 0 = row y-2, 1 = row y-1, 2 = row y.
    logic [2:0][DATA_W-1:0]        col_new, col_m1, col_m2;
    logic [2:0][DATA_W-1:0]        win_m1_q, win_m1_d, win_m2_q, win_m2_d;
    logic [WIN_TAPS*DATA_W-1:0]    win_flat, win_rank;
    logic [DATA_W-1:0]             rank_min, rank_med, rank_max, result;

    logic                          out_valid_q, out_valid_d;
    logic [DATA_W-1:0]             out_pixel_q, out_pixel_d;
    logic                          out_sof_q, out_sof_d;
    logic                          out_eol_q, out_eol_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // An accepted sof forces the pixel to (0,0) and brings its mode along with it.
    assign x_cur    = in_sof ? '0 : x_q;
    assign y_cur    = in_sof ? '0 : y_q;
    assign mode_cur = in_sof ? mode : mode_q;
    assign x_last   = (x_cur == X_LAST);

    assign lb0_rd = lb0_q[x_cur];
    assign lb1_rd = lb1_q[x_cur];

    always_comb begin
        col_new[2] = in_pixel;
        if (y_cur == '0) begin
            col_new[1] = in_pixel;
            col_new[0] = in_pixel;
        end else if (y_cur == YW'(1)) begin
            col_new[1] = lb0_rd;
            col_new[0] = lb0_rd;
        end else begin
            col_new[1] = lb0_rd;
            col_new[0] = lb1_rd;
        end
    end

    // At the start of a line the new column stands in for both older columns.
    assign col_m1   = (x_cur == '0) ? col_new : win_m1_q;
    assign col_m2   = (x_cur == '0) ? col_new : win_m2_q;
    assign win_flat = {col_m2, col_m1, col_new};

    generate
        if (BORDER_MODE == BORDER_ZERO) begin : g_border_zero
            assign win_rank = (x_cur < XW'(2) || y_cur < YW'(2)) ? '0 : win_flat;
        end else begin : g_border_replicate
            assign win_rank = win_flat;
        end
    endgenerate

    rank9_sorter #(
        .DATA_W (DATA_W)
    ) u_sorter (
        .win_i  (win_rank),
        .min_o  (rank_min),
        .med_o  (rank_med),
        .max_o  (rank_max)
    );

    always_comb begin
        case (mode_cur)
            MODE_MIN:    result = rank_min;
            MODE_MAX:    result = rank_max;
            MODE_BYPASS: result = in_pixel;
            default:     result = rank_med;
        endcase
    end

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        mode_d    = mode_q;
        len_err_d = len_err_q;
        win_m1_d  = win_m1_q;
        win_m2_d  = win_m2_q;
        if (accept) begin
            win_m2_d  = col_m1;
            win_m1_d  = col_new;
            if (in_sof) begin
                mode_d = mode;
            end
            len_err_d = (in_sof ? 1'b0 : len_err_q) | (x_last && !in_eol);
            if (in_eol || x_last) begin
                x_d = '0;
                y_d = (y_cur == Y_LAST) ? '0 : y_cur + YW'(1);
            end else begin
                x_d = x_cur + XW'(1);
                y_d = y_cur;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_pixel_d = out_pixel_q;
        out_sof_d   = out_sof_q;
        out_eol_d   = out_eol_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_pixel_d = result;
            out_sof_d   = in_sof;
            out_eol_d   = in_eol;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q         <= '0;
            y_q         <= '0;
            mode_q      <= MODE_MEDIAN;
            len_err_q   <= 1'b0;
            win_m1_q    <= '0;
            win_m2_q    <= '0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            mode_q      <= mode_d;
            len_err_q   <= len_err_d;
            win_m1_q    <= win_m1_d;
            win_m2_q    <= win_m2_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            out_sof_q   <= out_sof_d;
            out_eol_q   <= out_eol_d;
        end
    end

    // Line buffers carry no reset so they can map onto RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0_q[x_cur] <= in_pixel;
            lb1_q[x_cur] <= lb0_rd;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;
    assign len_err   = len_err_q;

endmodule

`default_nettype wire

// File: tb/tb_rank3x3_stream.sv
// ============================================================================
//  Module      : tb_rank3x3_stream
//  Description : Randomised self-checking bench for rank3x3_stream (both border modes).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rank3x3_stream;
    import rank_pkg::*;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [1:0]    mode = MODE_MEDIAN;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_pixel = '0;
    logic          in_sof = 1'b0;
    logic          in_eol = 1'b0;
    logic          out_ready = 1'b1;

    logic          rdy  [2];
    logic          ov   [2];
    logic [DW-1:0] op   [2];
    logic          osof [2];
    logic          oeol [2];
    logic          lerr [2];

    // Index 0: replicate border; index 1: zero-fill border.
    rank3x3_stream #(.W(W), .H(H), .DATA_W(DW), .BORDER_MODE(BORDER_REPLICATE)) u_dut_rep (
        .clk(clk), .resetn(resetn), .mode(mode),
        .in_valid(in_valid), .in_ready(rdy[0]), .in_pixel(in_pixel),
        .in_sof(in_sof), .in_eol(in_eol),
        .out_valid(ov[0]), .out_ready(out_ready), .out_pixel(op[0]),
        .out_sof(osof[0]), .out_eol(oeol[0]), .len_err(lerr[0])
    );

    rank3x3_stream #(.W(W), .H(H), .DATA_W(DW), .BORDER_MODE(BORDER_ZERO)) u_dut_zero (
        .clk(clk), .resetn(resetn), .mode(mode),
        .in_valid(in_valid), .in_ready(rdy[1]), .in_pixel(in_pixel),
        .in_sof(in_sof), .in_eol(in_eol),
        .out_valid(ov[1]), .out_ready(out_ready), .out_pixel(op[1]),
        .out_sof(osof[1]), .out_eol(oeol[1]), .len_err(lerr[1])
    );

    initial begin
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state: coordinates, latched mode, sticky length error,
    // one pending expected output per DUT, and the image as written so far.
    int            mx [2];
    int            my [2];
    int            mmode [2];
    bit            mlen [2];
    bit            expv [2];
    logic [DW-1:0] expp [2];
    bit            exps [2];
    bit            expe [2];
    logic [DW-1:0] img [H][W];
    logic [DW-1:0] fr  [H][W];

    bit stall_en  = 1'b0;
    int stall_cnt = 0;
    bit count_en  = 1'b0;
    int cnt255    = 0;

    function automatic logic [DW-1:0] ref_pix(int x, int y, int md, bit zero, logic [DW-1:0] p);
        logic [DW-1:0] v [9];
        logic [DW-1:0] t;
        int n, r, c;
        if (md == 3) return p;
        if (zero && (x < 2 || y < 2)) return '0;
        n = 0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                r = (y - 2 + dr < 0) ? 0 : y - 2 + dr;
                c = (x - 2 + dc < 0) ? 0 : x - 2 + dc;
                v[n] = img[r][c];
                n++;
            end
        end
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
            end
        end
        case (md)
            1:       return v[0];
            2:       return v[8];
            default: return v[4];
        endcase
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!resetn) begin
                check($sformatf("d%0d_rst_out_valid", d), ov[d], 0);
                check($sformatf("d%0d_rst_out_pixel", d), op[d], 0);
                check($sformatf("d%0d_rst_len_err", d), lerr[d], 0);
                mx[d] = 0; my[d] = 0; mmode[d] = 0; mlen[d] = 1'b0; expv[d] = 1'b0;
            end else begin
                check($sformatf("d%0d_out_valid", d), ov[d], expv[d]);
                if (expv[d] && ov[d]) begin
                    check($sformatf("d%0d_out_pixel", d), op[d], expp[d]);
                    check($sformatf("d%0d_out_sof", d), osof[d], exps[d]);
                    check($sformatf("d%0d_out_eol", d), oeol[d], expe[d]);
                end
                check($sformatf("d%0d_len_err", d), lerr[d], mlen[d]);
                if (ov[d] && out_ready) begin
                    expv[d] = 1'b0;
                    if (d == 0 && count_en && op[d] == 8'd255) cnt255++;
                end
                if (in_valid && rdy[d]) begin
                    if (in_sof) begin
                        mx[d] = 0; my[d] = 0; mmode[d] = int'(mode); mlen[d] = 1'b0;
                    end
                    img[my[d]][mx[d]] = in_pixel;
                    expp[d] = ref_pix(mx[d], my[d], mmode[d], d == 1, in_pixel);
                    exps[d] = in_sof;
                    expe[d] = in_eol;
                    expv[d] = 1'b1;
                    if (mx[d] == W - 1 && !in_eol) mlen[d] = 1'b1;
                    if (in_eol || mx[d] == W - 1) begin
                        mx[d] = 0;
                        my[d] = (my[d] == H - 1) ? 0 : my[d] + 1;
                    end else begin
                        mx[d] = mx[d] + 1;
                    end
                end
            end
        end
    end

    initial begin : g_ready_pattern
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_en) begin
                out_ready = (k == 0 || k == 3);
                k = (k + 1) % 4;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic send_pixel(input logic [DW-1:0] p, input logic s, input logic e);
        int  tries;
        bit  done;
        tries = 0;
        done  = 1'b0;
        in_valid = 1'b1; in_pixel = p; in_sof = s; in_eol = e;
        while (!done) begin
            @(negedge clk);
            done = rdy[0];
            @(posedge clk);
            #1;
            if (!done) begin
                tries++;
                stall_cnt++;
                if (tries > 50) begin
                    check("handshake_timeout", 0, 1);
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    endtask

    task automatic send_frame(input bit use_sof, input int switch_at, input logic [1:0] switch_mode,
                              input int count);
        int idx;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                idx = y * W + x;
                if (idx < count) begin
                    if (idx == switch_at) mode = switch_mode;
                    send_pixel(fr[y][x], use_sof && idx == 0, x == W - 1);
                end
            end
        end
    endtask

    task automatic fill_flat(input logic [DW-1:0] v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                fr[y][x] = v;
    endtask

    task automatic fill_rand();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                fr[y][x] = DW'($urandom_range(0, 255));
    endtask

    task automatic send_run(input int n, input logic [DW-1:0] v, input bit sof_first, input bit eol_last);
        for (int i = 0; i < n; i++)
            send_pixel(v, sof_first && i == 0, eol_last && i == n - 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((expv[0] || expv[1]) && t < 40) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_timeout", 32'(expv[0] || expv[1]), 0);
    endtask

    localparam int FULL = W * H;

    initial begin
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = '0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Flat frame at full rate
        fill_flat(8'd100);
        mode = MODE_MEDIAN;
        stall_cnt = 0;
        send_frame(1'b1, -1, MODE_MEDIAN, FULL);
        check("t1_full_rate_stalls", stall_cnt, 0);

        // Single hot pixel: vanishes under median, spreads to 3x3 under max
        fill_flat(8'd100);
        fr[3][4] = 8'd255;
        send_frame(1'b1, -1, MODE_MEDIAN, FULL);
        mode = MODE_MAX;
        drain();
        cnt255 = 0;
        count_en = 1'b1;
        send_frame(1'b1, -1, MODE_MAX, FULL);
        drain();
        count_en = 1'b0;
        check("t2_max_255_count", cnt255, 9);

        // Flat 50 in min and max
        fill_flat(8'd50);
        mode = MODE_MIN;
        send_frame(1'b1, -1, MODE_MIN, FULL);
        mode = MODE_MAX;
        send_frame(1'b1, -1, MODE_MAX, FULL);

        // Random frames under back-pressure, then at full rate in all modes
        stall_en = 1'b1;
        fill_rand();
        mode = MODE_MEDIAN;
        send_frame(1'b1, -1, MODE_MEDIAN, FULL);
        fill_rand();
        mode = MODE_MIN;
        send_frame(1'b1, -1, MODE_MIN, FULL);
        drain();
        stall_en = 1'b0;
        for (int m = 0; m < 4; m++) begin
            fill_rand();
            mode = 2'(m);
            send_frame(1'b1, -1, 2'(m), FULL);
        end

        // Line-length handling
        fill_flat(8'd77);
        mode = MODE_MEDIAN;
        send_frame(1'b1, -1, MODE_MEDIAN, FULL);
        mode = MODE_MIN;
        send_run(8, 8'd77, 1'b1, 1'b1);
        send_run(5, 8'd77, 1'b0, 1'b1);
        check("t5_len_err_short_line", lerr[0], 0);
        send_run(9, 8'd77, 1'b0, 1'b0);
        check("t5_len_err_long_line", lerr[0], 1);
        check("t5_len_err_long_line_zero", lerr[1], 1);
        send_run(7, 8'd77, 1'b0, 1'b1);
        send_run(6, 8'd77, 1'b0, 1'b0);
        check("t5_len_err_sticky", lerr[0], 1);
        send_frame(1'b1, -1, MODE_MIN, FULL);
        check("t5_len_err_cleared_by_sof", lerr[0], 0);

        // Reset mid-frame, then mode latching across frames
        fill_rand();
        mode = MODE_MEDIAN;
        send_frame(1'b1, -1, MODE_MEDIAN, 2 * W + 3);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        mode = MODE_MAX;
        fill_rand();
        send_frame(1'b0, -1, MODE_MAX, FULL);
        fill_rand();
        mode = MODE_MEDIAN;
        send_frame(1'b1, 20, MODE_MAX, FULL);
        fill_rand();
        send_frame(1'b1, -1, MODE_MAX, FULL);
        fill_rand();
        mode = MODE_BYPASS;
        send_frame(1'b1, -1, MODE_BYPASS, FULL);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
